// File: rtl/filter_conv_controller_pkg.sv
// Shared definitions for the filter convolution controller: state encoding and its width.
package cnn_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE        = 3'd0,
        LOAD_FILTER = 3'd1,
        LOAD_WINDOW = 3'd2,
        CONV        = 3'd3,
        WRITE       = 3'd4,
        DONE        = 3'd5
    } ctrlState_t;

endpackage

// File: rtl/filter_conv_controller_if.sv
// Handshake bundle between the layer controller / DMA-MAC datapath (master) and the
// filter convolution controller (slave).
interface filter_conv_controller_if #(
    parameter int CH_W  = 3,
    parameter int POS_W = 8
);
    logic             startFilterConv;
    logic [CH_W-1:0]  channelsNumber;
    logic [POS_W-1:0] outputSize;
    logic             dmaFinish;
    logic             convFinish;
    logic             writeDone;
    logic             loadFilter;
    logic             loadWindow;
    logic             startConv;
    logic             writeResult;
    logic [CH_W-1:0]  channelIndex;
    logic [POS_W-1:0] positionIndex;
    logic             filterFinish;

    modport master (
        output startFilterConv, channelsNumber, outputSize, dmaFinish, convFinish, writeDone,
        input  loadFilter, loadWindow, startConv, writeResult, channelIndex, positionIndex,
               filterFinish
    );

    modport slave (
        input  startFilterConv, channelsNumber, outputSize, dmaFinish, convFinish, writeDone,
        output loadFilter, loadWindow, startConv, writeResult, channelIndex, positionIndex,
               filterFinish
    );

endinterface

// File: rtl/filter_conv_controller_ctrl_counter.sv
// Saturating index counter that latches its own last value (count-1, zero treated as one)
// and reports when the index has reached it.
module ctrl_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         resetStateN,
    input  logic         load_i,
    input  logic [W-1:0] count_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] value_o,
    output logic         atLast_o
);

    logic [W-1:0] value_q, value_d;
    logic [W-1:0] last_q, last_d;

    always_comb begin
        value_d = value_q;
        last_d  = last_q;
        if (load_i) begin
            last_d = (count_i == '0) ? '0 : count_i - W'(1);
        end
        // The last-value guard keeps the index from ever wrapping.
        if (clear_i) begin
            value_d = '0;
        end else if (inc_i && (value_q != last_q)) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetStateN) begin
        if (!resetStateN) begin
            value_q <= '0;
            last_q  <= '0;
        end else begin
            value_q <= value_d;
            last_q  <= last_d;
        end
    end

    assign value_o  = value_q;
    assign atLast_o = (value_q == last_q);

endmodule

// File: rtl/filter_conv_controller.sv
// Responder for the layer/filter handshake: sequences one filter's weight load, then per
// position and channel a window load and MAC run, then a result write, and reports done.
module filter_conv_controller
    import cnn_ctrl_pkg::*;
#(
    parameter int CH_W  = 3,
    parameter int POS_W = 8
) (
    input logic                    clk,
    input logic                    resetStateN,
    filter_conv_controller_if.slave bus
);

    ctrlState_t       state_q, state_d;
    logic             startConv_q;
    logic             latchCounts;
    logic             clearIdx;
    logic             chInc;
    logic             chClear;
    logic             posInc;
    logic             chAtLast;
    logic             posAtLast;
    logic [CH_W-1:0]  chValue;
    logic [POS_W-1:0] posValue;

    always_comb begin
        state_d     = state_q;
        latchCounts = 1'b0;
        clearIdx    = 1'b0;
        chInc       = 1'b0;
        chClear     = 1'b0;
        posInc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.startFilterConv) begin
                    latchCounts = 1'b1;
                    clearIdx    = 1'b1;
                    state_d     = LOAD_FILTER;
                end
            end
            LOAD_FILTER: if (bus.dmaFinish) state_d = LOAD_WINDOW;
            LOAD_WINDOW: if (bus.dmaFinish) state_d = CONV;
            CONV: begin
                if (bus.convFinish) begin
                    if (!chAtLast) begin
                        chInc   = 1'b1;
                        state_d = LOAD_WINDOW;
                    end else begin
                        chClear = 1'b1;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.writeDone) begin
                    if (!posAtLast) begin
                        posInc  = 1'b1;
                        state_d = LOAD_WINDOW;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: if (!bus.startFilterConv) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A dropped request mid-filter overrides every other transition.
        if ((state_q != IDLE) && (state_q != DONE) && !bus.startFilterConv) begin
            state_d  = IDLE;
            clearIdx = 1'b1;
            chInc    = 1'b0;
            chClear  = 1'b0;
            posInc   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetStateN) begin
        if (!resetStateN) begin
            state_q     <= IDLE;
            startConv_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            startConv_q <= (state_d == CONV) && (state_q != CONV);
        end
    end

    ctrl_counter #(.W(CH_W)) u_chCounter (
        .clk         (clk),
        .resetStateN (resetStateN),
        .load_i      (latchCounts),
        .count_i     (bus.channelsNumber),
        .clear_i     (clearIdx | chClear),
        .inc_i       (chInc),
        .value_o     (chValue),
        .atLast_o    (chAtLast)
    );

    ctrl_counter #(.W(POS_W)) u_posCounter (
        .clk         (clk),
        .resetStateN (resetStateN),
        .load_i      (latchCounts),
        .count_i     (bus.outputSize),
        .clear_i     (clearIdx),
        .inc_i       (posInc),
        .value_o     (posValue),
        .atLast_o    (posAtLast)
    );

    assign bus.loadFilter    = (state_q == LOAD_FILTER);
    assign bus.loadWindow    = (state_q == LOAD_WINDOW);
    assign bus.writeResult   = (state_q == WRITE);
    assign bus.filterFinish  = (state_q == DONE);
    assign bus.startConv     = startConv_q;
    assign bus.channelIndex  = chValue;
    assign bus.positionIndex = posValue;

endmodule

// File: tb/tb_filter_conv_controller.sv
// Self-checking bench: a datapath responder plus a scoreboard of expected MAC/write indices.
module tb_filter_conv_controller;

    logic clk = 1'b0;
    logic resetStateN = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   convWait = 1'b0;
    int   expCh[$];
    int   expPos[$];
    int   expWritePos[$];

    filter_conv_controller_if #(.CH_W(3), .POS_W(8)) bus ();

    filter_conv_controller #(.CH_W(3), .POS_W(8)) dut (
        .clk         (clk),
        .resetStateN (resetStateN),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Datapath model: DMA and write answer at once, MAC finishes one cycle after startConv.
    task automatic applyStimulus();
        bus.dmaFinish  = 1'b0;
        bus.convFinish = 1'b0;
        bus.writeDone  = 1'b0;
        if (bus.loadFilter || bus.loadWindow) bus.dmaFinish = 1'b1;
        if (bus.startConv) begin
            convWait = 1'b1;
        end else if (convWait) begin
            bus.convFinish = 1'b1;
            convWait       = 1'b0;
        end
        if (bus.writeResult) bus.writeDone = 1'b1;
    endtask

    task automatic runFilter(input int chN, input int posN,
                             output int nConv, output int nWrite, output int nWin, output int nFilt);
        int  chEff;
        int  posEff;
        int  e;
        bit  done;
        chEff  = (chN == 0) ? 1 : chN;
        posEff = (posN == 0) ? 1 : posN;
        for (int p = 0; p < posEff; p++) begin
            for (int c = 0; c < chEff; c++) begin
                expCh.push_back(c);
                expPos.push_back(p);
            end
            expWritePos.push_back(p);
        end
        nConv = 0; nWrite = 0; nWin = 0; nFilt = 0;
        done = 1'b0;
        convWait = 1'b0;
        @(negedge clk);
        bus.channelsNumber  = chN[2:0];
        bus.outputSize      = posN[7:0];
        bus.startFilterConv = 1'b1;
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            @(negedge clk);
            if (bus.filterFinish) begin
                done = 1'b1;
                total++;
                if (expWritePos.size() != 0 || expCh.size() != 0) begin
                    $display("[TB] FAIL finish_early got pendingWrites=%0d pendingConvs=%0d want 0/0",
                             expWritePos.size(), expCh.size());
                    bad++;
                end
            end
            if (bus.loadFilter) nFilt++;
            if (bus.loadWindow) nWin++;
            if (bus.startConv) begin
                nConv++;
                total++;
                if (expCh.size() == 0) begin
                    $display("[TB] FAIL conv_extra got ch=%0d pos=%0d want none",
                             bus.channelIndex, bus.positionIndex);
                    bad++;
                end else begin
                    e = expCh.pop_front();
                    if (int'(bus.channelIndex) !== e) begin
                        $display("[TB] FAIL conv_ch got=%0d want=%0d", bus.channelIndex, e);
                        bad++;
                    end
                    e = expPos.pop_front();
                    total++;
                    if (int'(bus.positionIndex) !== e) begin
                        $display("[TB] FAIL conv_pos got=%0d want=%0d", bus.positionIndex, e);
                        bad++;
                    end
                end
            end
            if (bus.writeResult) begin
                nWrite++;
                total++;
                if (expWritePos.size() == 0) begin
                    $display("[TB] FAIL write_extra got pos=%0d want none", bus.positionIndex);
                    bad++;
                end else begin
                    e = expWritePos.pop_front();
                    if (int'(bus.positionIndex) !== e) begin
                        $display("[TB] FAIL write_pos got=%0d want=%0d", bus.positionIndex, e);
                        bad++;
                    end
                end
            end
            applyStimulus();
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL finish_timeout got filterFinish=0 want 1");
        end
        expCh.delete();
        expPos.delete();
        expWritePos.delete();
        bus.dmaFinish  = 1'b0;
        bus.convFinish = 1'b0;
        bus.writeDone  = 1'b0;
    endtask

    task automatic dropRequest(input string tag);
        bus.startFilterConv = 1'b0;
        @(negedge clk);
        total++;
        if (bus.filterFinish !== 1'b0 || bus.loadFilter !== 1'b0) begin
            $display("[TB] FAIL %s_idle got finish=%b loadFilter=%b want 0/0",
                     tag, bus.filterFinish, bus.loadFilter);
            bad++;
        end
    endtask

    task automatic test_reset();
        bus.startFilterConv = 1'b0;
        bus.channelsNumber  = '0;
        bus.outputSize      = '0;
        bus.dmaFinish       = 1'b0;
        bus.convFinish      = 1'b0;
        bus.writeDone       = 1'b0;
        resetStateN         = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({bus.loadFilter, bus.loadWindow, bus.startConv, bus.writeResult, bus.filterFinish,
             bus.channelIndex, bus.positionIndex} !== '0) begin
            $display("[TB] FAIL reset_outputs got lf=%b lw=%b sc=%b wr=%b ff=%b ch=%0d pos=%0d want all 0",
                     bus.loadFilter, bus.loadWindow, bus.startConv, bus.writeResult,
                     bus.filterFinish, bus.channelIndex, bus.positionIndex);
            bad++;
        end
        resetStateN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_three_by_two();
        int nConv, nWrite, nWin, nFilt;
        runFilter(3, 2, nConv, nWrite, nWin, nFilt);
        total++;
        if (nConv != 6 || nWrite != 2 || nWin != 6 || nFilt != 1) begin
            $display("[TB] FAIL counts_3x2 got conv=%0d write=%0d win=%0d filt=%0d want 6/2/6/1",
                     nConv, nWrite, nWin, nFilt);
            bad++;
        end
        dropRequest("after_3x2");
    endtask

    task automatic test_zero_counts();
        int nConv, nWrite, nWin, nFilt;
        runFilter(0, 0, nConv, nWrite, nWin, nFilt);
        total++;
        if (nConv != 1 || nWrite != 1 || nWin != 1 || nFilt != 1) begin
            $display("[TB] FAIL counts_zero got conv=%0d write=%0d win=%0d filt=%0d want 1/1/1/1",
                     nConv, nWrite, nWin, nFilt);
            bad++;
        end
        dropRequest("after_zero");
    endtask

    task automatic test_done_hold();
        int nConv, nWrite, nWin, nFilt;
        runFilter(1, 1, nConv, nWrite, nWin, nFilt);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.filterFinish !== 1'b1 || bus.loadFilter !== 1'b0) begin
                $display("[TB] FAIL done_hold cycle=%0d got finish=%b loadFilter=%b want 1/0",
                         i, bus.filterFinish, bus.loadFilter);
                bad++;
            end
        end
        dropRequest("done_release");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.loadFilter !== 1'b0 || bus.filterFinish !== 1'b0) begin
                $display("[TB] FAIL no_retrigger cycle=%0d got loadFilter=%b finish=%b want 0/0",
                         i, bus.loadFilter, bus.filterFinish);
                bad++;
            end
        end
    endtask

    task automatic test_abort();
        bit hit;
        hit = 1'b0;
        convWait = 1'b0;
        @(negedge clk);
        bus.channelsNumber  = 3'd2;
        bus.outputSize      = 8'd3;
        bus.startFilterConv = 1'b1;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(negedge clk);
            if (bus.loadWindow && bus.positionIndex == 8'd1) begin
                hit = 1'b1;
                bus.dmaFinish  = 1'b0;
                bus.convFinish = 1'b0;
                bus.writeDone  = 1'b0;
            end else begin
                applyStimulus();
            end
        end
        total++;
        if (!hit) begin
            $display("[TB] FAIL abort_reach got position1 window=0 want 1");
            bad++;
        end
        bus.startFilterConv = 1'b0;
        @(negedge clk);
        total++;
        if (bus.loadWindow !== 1'b0 || bus.channelIndex !== 3'd0 || bus.positionIndex !== 8'd0) begin
            $display("[TB] FAIL abort_state got lw=%b ch=%0d pos=%0d want 0/0/0",
                     bus.loadWindow, bus.channelIndex, bus.positionIndex);
            bad++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (bus.filterFinish !== 1'b0 || bus.loadFilter !== 1'b0) begin
                $display("[TB] FAIL abort_quiet cycle=%0d got finish=%b loadFilter=%b want 0/0",
                         i, bus.filterFinish, bus.loadFilter);
                bad++;
            end
        end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        bus.channelsNumber  = 3'd2;
        bus.outputSize      = 8'd1;
        bus.startFilterConv = 1'b1;
        @(negedge clk);
        bus.dmaFinish = 1'b1;
        @(negedge clk);
        bus.dmaFinish  = 1'b0;
        bus.convFinish = 1'b1;
        @(negedge clk);
        bus.convFinish = 1'b0;
        total++;
        if (bus.loadWindow !== 1'b1 || bus.startConv !== 1'b0 || bus.channelIndex !== 3'd0) begin
            $display("[TB] FAIL spurious_conv got lw=%b sc=%b ch=%0d want 1/0/0",
                     bus.loadWindow, bus.startConv, bus.channelIndex);
            bad++;
        end
        bus.dmaFinish = 1'b1;
        @(negedge clk);
        total++;
        if (bus.startConv !== 1'b1) begin
            $display("[TB] FAIL spurious_enter_conv got sc=%b want 1", bus.startConv);
            bad++;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (bus.startConv !== 1'b0 || bus.loadWindow !== 1'b0 || bus.writeResult !== 1'b0) begin
                $display("[TB] FAIL spurious_dma cycle=%0d got sc=%b lw=%b wr=%b want 0/0/0",
                         i, bus.startConv, bus.loadWindow, bus.writeResult);
                bad++;
            end
        end
        bus.dmaFinish  = 1'b0;
        bus.convFinish = 1'b1;
        @(negedge clk);
        bus.convFinish = 1'b0;
        total++;
        if (bus.loadWindow !== 1'b1 || bus.channelIndex !== 3'd1) begin
            $display("[TB] FAIL spurious_next_ch got lw=%b ch=%0d want 1/1",
                     bus.loadWindow, bus.channelIndex);
            bad++;
        end
        dropRequest("spurious_cleanup");
    endtask

    task automatic test_reset_mid_conv();
        int nConv, nWrite, nWin, nFilt;
        @(negedge clk);
        bus.channelsNumber  = 3'd2;
        bus.outputSize      = 8'd2;
        bus.startFilterConv = 1'b1;
        @(negedge clk);
        bus.dmaFinish = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.dmaFinish = 1'b0;
        total++;
        if (bus.startConv !== 1'b1) begin
            $display("[TB] FAIL midconv_enter got sc=%b want 1", bus.startConv);
            bad++;
        end
        resetStateN = 1'b0;
        #1;
        total++;
        if ({bus.loadFilter, bus.loadWindow, bus.startConv, bus.writeResult, bus.filterFinish,
             bus.channelIndex, bus.positionIndex} !== '0) begin
            $display("[TB] FAIL midconv_reset got lf=%b lw=%b sc=%b wr=%b ff=%b want all 0",
                     bus.loadFilter, bus.loadWindow, bus.startConv, bus.writeResult, bus.filterFinish);
            bad++;
        end
        bus.startFilterConv = 1'b0;
        @(negedge clk);
        resetStateN = 1'b1;
        @(negedge clk);
        total++;
        if (bus.loadFilter !== 1'b0 || bus.startConv !== 1'b0) begin
            $display("[TB] FAIL midconv_idle got lf=%b sc=%b want 0/0", bus.loadFilter, bus.startConv);
            bad++;
        end
        runFilter(2, 2, nConv, nWrite, nWin, nFilt);
        total++;
        if (nConv != 4 || nWrite != 2) begin
            $display("[TB] FAIL midconv_recover got conv=%0d write=%0d want 4/2", nConv, nWrite);
            bad++;
        end
        dropRequest("midconv_cleanup");
    endtask

    initial begin
        test_reset();
        test_three_by_two();
        test_zero_counts();
        test_done_hold();
        test_abort();
        test_spurious();
        test_reset_mid_conv();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
